// File: rtl/rv_core_pkg.sv
// ============================================================================
// Module      : rv_core_pkg
// Description : Shared constants for the multi-cycle RV32I core: opcode
//               values, ALU operation codes, next-PC select encodings and
//               the reset/bubble instruction.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv_core_pkg;

    // Major opcodes, IR[6:0]
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // funct3 values that qualify the load/store/branch classes
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_SR  = 3'b101;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // Next-PC select encodings
    localparam logic [1:0] PC_S_PLUS4  = 2'b00;
    localparam logic [1:0] PC_S_BRANCH = 2'b01;
    localparam logic [1:0] PC_S_JALR   = 2'b10;
    localparam logic [1:0] PC_S_HOLD   = 2'b11;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage : rv_core_pkg

`default_nettype wire

// File: rtl/inst_decode.sv
// ============================================================================
// Module      : inst_decode
// Description : Purely combinational RV32I decoder. Maps the instruction
//               register to one-hot class flags, ALU operation code,
//               sign-extended immediate and an illegal-instruction detect.
// Ports       : ir        in  32  instruction to decode
//               is_*      out 1   one-hot class flags (all 0 if unknown)
//               alu_op    out 4   ALU operation code
//               imm       out 32  sign-extended immediate
//               illegal   out 1   no listed class matched
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inst_decode
    import rv_core_pkg::*;
(
    input  logic [31:0] ir,
    output logic        is_r,
    output logic        is_imm,
    output logic        is_lui,
    output logic        is_lw,
    output logic        is_sw,
    output logic        is_beq,
    output logic        is_jalr,
    output logic        is_jal,
    output logic [3:0]  alu_op,
    output logic [31:0] imm,
    output logic        illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;

    assign w_opcode = ir[6:0];
    assign w_funct3 = ir[14:12];

    // Class flags and ALU code
    always_comb begin
        is_r    = 1'b0;
        is_imm  = 1'b0;
        is_lui  = 1'b0;
        is_lw   = 1'b0;
        is_sw   = 1'b0;
        is_beq  = 1'b0;
        is_jalr = 1'b0;
        is_jal  = 1'b0;
        alu_op  = ALU_ADD;
        case (w_opcode)
            OPC_OP: begin
                is_r   = 1'b1;
                alu_op = {ir[30], w_funct3};
            end
            OPC_OP_IMM: begin
                is_imm = 1'b1;
                // Only the shift-right pair uses bit 30 as the arith/logic
                // selector; for other I-type ops bit 30 is immediate data.
                alu_op = (w_funct3 == F3_SR) ? {ir[30], w_funct3}
                                             : {1'b0, w_funct3};
            end
            OPC_LUI:    is_lui  = 1'b1;
            OPC_LOAD:   is_lw   = (w_funct3 == F3_LW);
            OPC_STORE:  is_sw   = (w_funct3 == F3_SW);
            OPC_BRANCH: is_beq  = (w_funct3 == F3_BEQ);
            OPC_JALR:   is_jalr = 1'b1;
            OPC_JAL:    is_jal  = 1'b1;
            default: ;
        endcase
    end

    // Immediate format follows the opcode alone
    always_comb begin
        imm = 32'h0000_0000;
        case (w_opcode)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR:
                imm = {{20{ir[31]}}, ir[31:20]};
            OPC_STORE:
                imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH:
                imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_LUI:
                imm = {ir[31:12], 12'h000};
            OPC_JAL:
                imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default: ;
        endcase
    end

    assign illegal = ~(is_r | is_imm | is_lui | is_lw | is_sw |
                       is_beq | is_jalr | is_jal);

endmodule : inst_decode

`default_nettype wire

// File: rtl/if_id_unit.sv
// ============================================================================
// Module      : if_id_unit
// Description : Instruction fetch/decode stage of the multi-cycle RV32I core.
//               Holds PC, PC0 (address of the instruction in IR) and IR,
//               selects the next PC, and exposes the decoded IR fields.
// Ports       : clk, rst_n               clock, async active-low reset
//               PC_Write/PC0_Write/IR_Write  register load strobes
//               PC_s                     next-PC select
//               rs1_data                 JALR base
//               inst_data / inst_addr    instruction ROM interface
//               PC, PC0, IR              architectural registers
//               rs1, rs2, rd, imm        decoded fields
//               IS_*, ALU_OP             class flags and ALU code
//               illegal                  sticky illegal-instruction flag
// Config      : ILLEGAL_INST_TRAP_EN - when defined, an undecodable IR sets
//               the sticky illegal flag and freezes all three registers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = rv_core_pkg::NOP_INST
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PC_Write,
    input  logic        PC0_Write,
    input  logic        IR_Write,
    input  logic [1:0]  PC_s,
    input  logic [31:0] rs1_data,
    input  logic [31:0] inst_data,
    output logic [31:0] inst_addr,
    output logic [31:0] PC,
    output logic [31:0] PC0,
    output logic [31:0] IR,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] imm,
    output logic        IS_R,
    output logic        IS_IMM,
    output logic        IS_LUI,
    output logic        IS_LW,
    output logic        IS_SW,
    output logic        IS_BEQ,
    output logic        IS_JALR,
    output logic        IS_JAL,
    output logic [3:0]  ALU_OP,
    output logic        illegal
);

    import rv_core_pkg::*;

    logic [31:0] r_pc;
    logic [31:0] r_pc0;
    logic [31:0] r_ir;
    logic [31:0] w_next_pc;
    logic        w_pc_we;
    logic        w_pc0_we;
    logic        w_ir_we;
    logic        w_dec_illegal;

    inst_decode u_inst_decode (
        .ir      (r_ir),
        .is_r    (IS_R),
        .is_imm  (IS_IMM),
        .is_lui  (IS_LUI),
        .is_lw   (IS_LW),
        .is_sw   (IS_SW),
        .is_beq  (IS_BEQ),
        .is_jalr (IS_JALR),
        .is_jal  (IS_JAL),
        .alu_op  (ALU_OP),
        .imm     (imm),
        .illegal (w_dec_illegal)
    );

`ifdef ILLEGAL_INST_TRAP_EN
    logic r_illegal;

    // The flag looks at the IR held before the edge, so it rises one edge
    // after the offending instruction lands and never clears until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegal <= 1'b0;
        end else begin
            r_illegal <= r_illegal | w_dec_illegal;
        end
    end

    assign w_pc_we  = PC_Write  & ~r_illegal;
    assign w_pc0_we = PC0_Write & ~r_illegal;
    assign w_ir_we  = IR_Write  & ~r_illegal;
    assign illegal  = r_illegal;
`else
    logic w_unused_illegal;

    assign w_unused_illegal = w_dec_illegal;
    assign w_pc_we          = PC_Write;
    assign w_pc0_we         = PC0_Write;
    assign w_ir_we          = IR_Write;
    assign illegal          = 1'b0;
`endif

    // Branch/JAL targets are relative to PC0 so they stay correct after PC
    // has already advanced to PC+4 during fetch.
    always_comb begin
        w_next_pc = r_pc;
        case (PC_s)
            PC_S_PLUS4:  w_next_pc = r_pc + 32'd4;
            PC_S_BRANCH: w_next_pc = r_pc0 + imm;
            PC_S_JALR:   w_next_pc = (rs1_data + imm) & 32'hFFFF_FFFE;
            PC_S_HOLD:   w_next_pc = r_pc;
            default:     w_next_pc = r_pc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_PC;
            r_pc0 <= 32'h0000_0000;
            r_ir  <= NOP_INST;
        end else begin
            if (w_pc_we) begin
                r_pc <= w_next_pc;
            end
            if (w_pc0_we) begin
                r_pc0 <= r_pc;
            end
            if (w_ir_we) begin
                r_ir <= inst_data;
            end
        end
    end

    assign PC        = r_pc;
    assign PC0       = r_pc0;
    assign IR        = r_ir;
    assign inst_addr = r_pc;
    assign rs1       = r_ir[19:15];
    assign rs2       = r_ir[24:20];
    assign rd        = r_ir[11:7];

endmodule : if_id_unit

`default_nettype wire

// File: tb/tb_if_id_unit.sv
// ============================================================================
// Module      : tb_if_id_unit
// Description : Self-checking bench for if_id_unit. Directed scenarios
//               followed by randomized strobes/instructions, compared against
//               an instruction-level reference model.
// Config      : follows ILLEGAL_INST_TRAP_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_id_unit;

    localparam logic [31:0] C_RESET_PC = 32'h0000_0100;
    localparam logic [31:0] C_NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic        PC_Write;
    logic        PC0_Write;
    logic        IR_Write;
    logic [1:0]  PC_s;
    logic [31:0] rs1_data;
    logic [31:0] inst_data;
    logic [31:0] inst_addr;
    logic [31:0] PC;
    logic [31:0] PC0;
    logic [31:0] IR;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW, IS_BEQ, IS_JALR, IS_JAL;
    logic [3:0]  ALU_OP;
    logic        illegal;

    int n_cmp;
    int n_bad;

    // Reference state
    logic [31:0] m_pc;
    logic [31:0] m_pc0;
    logic [31:0] m_ir;
    logic        m_ill;

    if_id_unit #(
        .RESET_PC (C_RESET_PC),
        .NOP_INST (C_NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PC_Write  (PC_Write),
        .PC0_Write (PC0_Write),
        .IR_Write  (IR_Write),
        .PC_s      (PC_s),
        .rs1_data  (rs1_data),
        .inst_data (inst_data),
        .inst_addr (inst_addr),
        .PC        (PC),
        .PC0       (PC0),
        .IR        (IR),
        .rs1       (rs1),
        .rs2       (rs2),
        .rd        (rd),
        .imm       (imm),
        .IS_R      (IS_R),
        .IS_IMM    (IS_IMM),
        .IS_LUI    (IS_LUI),
        .IS_LW     (IS_LW),
        .IS_SW     (IS_SW),
        .IS_BEQ    (IS_BEQ),
        .IS_JALR   (IS_JALR),
        .IS_JAL    (IS_JAL),
        .ALU_OP    (ALU_OP),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model (instruction-level) ----------------
    // Class index: 0 R,1 IMM,2 LUI,3 LW,4 SW,5 BEQ,6 JALR,7 JAL, -1 unknown
    function automatic int ref_class(input logic [31:0] ins);
        int f3;
        f3 = int'(ins[14:12]);
        case (ins[6:0])
            7'h33: return 0;
            7'h13: return 1;
            7'h37: return 2;
            7'h03: return (f3 == 2) ? 3 : -1;
            7'h23: return (f3 == 2) ? 4 : -1;
            7'h63: return (f3 == 0) ? 5 : -1;
            7'h67: return 6;
            7'h6F: return 7;
            default: return -1;
        endcase
    endfunction

    // Packed as {IS_R,IS_IMM,IS_LUI,IS_LW,IS_SW,IS_BEQ,IS_JALR,IS_JAL}
    function automatic logic [7:0] ref_flags(input logic [31:0] ins);
        int c;
        c = ref_class(ins);
        if (c < 0) return 8'h00;
        return 8'h80 >> c;
    endfunction

    function automatic logic [3:0] ref_alu(input logic [31:0] ins);
        if (ins[6:0] == 7'h33) return {ins[30], ins[14:12]};
        if (ins[6:0] == 7'h13)
            return (ins[14:12] == 3'd5) ? {ins[30], ins[14:12]} : {1'b0, ins[14:12]};
        return 4'd0;
    endfunction

    // Immediates built as signed integers from the scattered fields
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: v = int'(ins[31:20]) - (ins[31] ? 4096 : 0);
            7'h23: v = int'({ins[31:25], ins[11:7]}) - (ins[31] ? 4096 : 0);
            7'h63: v = int'({ins[7], ins[30:25], ins[11:8]}) * 2 - (ins[31] ? 4096 : 0);
            7'h37: v = int'(ins[31:12]) * 4096;
            7'h6F: v = int'({ins[19:12], ins[20], ins[30:21]}) * 2 - (ins[31] ? (1 << 20) : 0);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic model_reset();
        m_pc  = C_RESET_PC;
        m_pc0 = 32'h0;
        m_ir  = C_NOP;
        m_ill = 1'b0;
    endtask

    task automatic check_all(input string where);
        check({where, ".pc"},   PC,        m_pc);
        check({where, ".addr"}, inst_addr, m_pc);
        check({where, ".pc0"},  PC0,       m_pc0);
        check({where, ".ir"},   IR,        m_ir);
        check({where, ".regs"}, {17'd0, rs1, rs2, rd},
              {17'd0, m_ir[19:15], m_ir[24:20], m_ir[11:7]});
        check({where, ".imm"},  imm,       ref_imm(m_ir));
        check({where, ".cls"},  {24'd0, IS_R, IS_IMM, IS_LUI, IS_LW, IS_SW,
                                 IS_BEQ, IS_JALR, IS_JAL}, {24'd0, ref_flags(m_ir)});
        check({where, ".alu"},  {28'd0, ALU_OP}, {28'd0, ref_alu(m_ir)});
        check({where, ".ill"},  {31'd0, illegal}, {31'd0, m_ill});
    endtask

    // Drive one cycle's strobes, advance the model at the edge, check at the
    // following falling edge.
    task automatic step(input logic pcw, input logic pc0w, input logic irw,
                        input logic [1:0] pcs, input logic [31:0] r1,
                        input logic [31:0] ins);
        logic [31:0] npc;
        logic [31:0] old_ir;
        PC_Write  = pcw;
        PC0_Write = pc0w;
        IR_Write  = irw;
        PC_s      = pcs;
        rs1_data  = r1;
        inst_data = ins;
        @(posedge clk);
        old_ir = m_ir;
        case (pcs)
            2'd0:    npc = m_pc + 32'd4;
            2'd1:    npc = m_pc0 + ref_imm(m_ir);
            2'd2:    npc = (r1 + ref_imm(m_ir)) & ~32'd1;
            default: npc = m_pc;
        endcase
        if (!m_ill) begin
            if (pc0w) m_pc0 = m_pc;
            if (irw)  m_ir  = ins;
            if (pcw)  m_pc  = npc;
        end
`ifdef ILLEGAL_INST_TRAP_EN
        if (ref_class(old_ir) < 0) m_ill = 1'b1;
`endif
        @(negedge clk);
        check_all("step");
    endtask

    function automatic logic [31:0] rand_inst();
        logic [31:0] ins;
        logic [6:0]  ops [8];
        ops = '{7'h33, 7'h13, 7'h37, 7'h03, 7'h23, 7'h63, 7'h67, 7'h6F};
        ins = $urandom;
        if ($urandom_range(0, 7) != 0) begin
            ins[6:0] = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 3) != 0) begin
                if (ins[6:0] == 7'h03 || ins[6:0] == 7'h23) ins[14:12] = 3'd2;
                if (ins[6:0] == 7'h63) ins[14:12] = 3'd0;
            end
        end
        return ins;
    endfunction

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        PC_Write = 1'b0; PC0_Write = 1'b0; IR_Write = 1'b0;
        PC_s = 2'd0; rs1_data = 32'h0; inst_data = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        check("reset.pc_const", PC, 32'h100);
        check("reset.ir_const", IR, 32'h13);
        rst_n = 1'b1;

        // add x3,x1,x2 fetched at 0x100
        step(1, 1, 1, 2'd0, 32'h0, 32'h0020_81B3);
        check("add.pc",  PC,  32'h104);
        check("add.pc0", PC0, 32'h100);
        check("add.isr", {31'd0, IS_R}, 32'd1);
        check("add.rd",  {27'd0, rd}, 32'd3);
        // sub, srai
        step(0, 0, 1, 2'd0, 32'h0, 32'h4020_81B3);
        check("sub.alu", {28'd0, ALU_OP}, 32'h8);
        step(0, 0, 1, 2'd0, 32'h0, 32'h4020_D093);
        check("srai.alu", {28'd0, ALU_OP}, 32'hD);
        check("srai.imm", imm, 32'h402);
        // jalr x0,4(x1) with rs1=0x1001
        step(0, 0, 1, 2'd0, 32'h0, 32'h0040_8067);
        step(1, 0, 0, 2'd2, 32'h1001, 32'h0);
        check("jalr.pc", PC, 32'h1004);
        // move to 0x200, fetch beq x0,x0,-8
        step(1, 0, 0, 2'd2, 32'h1FC, 32'h0);
        step(0, 1, 1, 2'd0, 32'h0, 32'hFE00_0CE3);
        check("beq.imm", imm, 32'hFFFF_FFF8);
        step(0, 0, 0, 2'd1, 32'h0, 32'h0);
        check("beq.nowr", PC, 32'h200);
        step(1, 0, 0, 2'd1, 32'h0, 32'h0);
        check("beq.pc", PC, 32'h1F8);
        // hold select with write enabled
        step(1, 0, 0, 2'd3, 32'h0, 32'h0);
        check("hold.pc", PC, 32'h1F8);
        // wrap
        step(0, 0, 1, 2'd0, 32'h0, 32'h0040_8067);
        step(1, 0, 0, 2'd2, 32'hFFFF_FFF8, 32'h0);
        step(1, 0, 0, 2'd0, 32'h0, 32'h0);
        check("wrap.pc", PC, 32'h0);

        // randomized traffic with periodic asynchronous resets
        for (int i = 0; i < 600; i++) begin
            if (i % 64 == 63) begin
                #1 rst_n = 1'b0;
                #1;
                model_reset();
                check_all("areset");
                #1 rst_n = 1'b1;
            end
            step(1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom),
                 $urandom, rand_inst());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

endmodule : tb_if_id_unit

`default_nettype wire
